pulse_stretch_gen: RTL and testbench

//  Tick-to-level generator: the opposite direction of our edge detectors. Takes 1-cycle ticks
//  (e.g. from edge_detect_* or a counter) and rebuilds a clean level pulse of fixed width,

---
 rtl/pulse_stretch_gen.sv | 122 ++++++++++++
 tb/tb_pulse_stretch_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretch_gen.sv
// Rebuilds a clean level pulse of fixed width from 1-cycle ticks, with an enforced
// minimum low gap and a single-entry pending slot so a tick during the gap is not lost.
//
// state  | meaning
// S_IDLE | waiting for a tick, level low
// S_HIGH | level held high, cnt counts remaining high cycles
// S_GAP  | enforced low gap, cnt counts remaining gap cycles, one tick may be pending
module pulse_stretch_gen #(
  parameter int unsigned HIGH_CYCLES = 4,
  parameter int unsigned LOW_CYCLES  = 2,
  parameter bit          RETRIGGER   = 1'b0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             tick_i,
  output logic             level_o,
  output logic             busy_o,
  output logic             dropped_o,
  output logic [CNT_W-1:0] pulse_count_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = (LOW_CYCLES == 0) ? '0 : CNT_W'(LOW_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pend_q, pend_d;
  logic             pend_nxt;
  logic             drop_d;
  logic             level_q, busy_q, dropped_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    count_d  = count_q;
    pend_d   = pend_q;
    pend_nxt = pend_q;
    drop_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick_i) begin
          state_d = S_HIGH;
          cnt_d   = HIGH_LOAD;
          count_d = count_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (tick_i && RETRIGGER) begin
          cnt_d = HIGH_LOAD;
        end else begin
          drop_d = tick_i;
          if (cnt_q == '0) begin
            if (LOW_CYCLES == 0) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = S_GAP;
              cnt_d   = LOW_LOAD;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_GAP: begin
        // A tick on the last gap cycle still lands in the pending slot and launches at once.
        pend_nxt = pend_q | tick_i;
        drop_d   = tick_i & pend_q;
        if (cnt_q == '0) begin
          pend_d = 1'b0;
          if (pend_nxt) begin
            state_d = S_HIGH;
            cnt_d   = HIGH_LOAD;
            count_d = count_q + 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d  = cnt_q - 1'b1;
          pend_d = pend_nxt;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
      level_q   <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      level_q   <= (state_d == S_HIGH);
      busy_q    <= (state_d != S_IDLE);
      dropped_q <= drop_d;
    end
  end

  assign level_o       = level_q;
  assign busy_o        = busy_q;
  assign dropped_o     = dropped_q;
  assign pulse_count_o = count_q;

endmodule

// File: tb/tb_pulse_stretch_gen.sv
// Bench for pulse_stretch_gen: four parameterisations driven in parallel, checked each cycle
// against a timeline model (end-of-high / end-of-gap cycle indices), plus literal scenario checks.
module tb_pulse_stretch_gen;
  localparam int N = 4;

  // instance 0: 4/2/no-retrigger, 1: 4/2/retrigger, 2: 4/0/no-retrigger, 3: 1/1/retrigger
  int hc [N] = '{4, 4, 4, 1};
  int lc [N] = '{2, 2, 0, 1};
  int rt [N] = '{0, 1, 0, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       lv [N];
  logic       bz [N];
  logic       dr [N];
  logic [7:0] pc [N];

  always #5 clk = ~clk;

  pulse_stretch_gen #(.HIGH_CYCLES(4), .LOW_CYCLES(2), .RETRIGGER(1'b0), .CNT_W(8)) u_a (
    .clk_i(clk), .reset_i(reset), .tick_i(tick),
    .level_o(lv[0]), .busy_o(bz[0]), .dropped_o(dr[0]), .pulse_count_o(pc[0]));
  pulse_stretch_gen #(.HIGH_CYCLES(4), .LOW_CYCLES(2), .RETRIGGER(1'b1), .CNT_W(8)) u_b (
    .clk_i(clk), .reset_i(reset), .tick_i(tick),
    .level_o(lv[1]), .busy_o(bz[1]), .dropped_o(dr[1]), .pulse_count_o(pc[1]));
  pulse_stretch_gen #(.HIGH_CYCLES(4), .LOW_CYCLES(0), .RETRIGGER(1'b0), .CNT_W(8)) u_c (
    .clk_i(clk), .reset_i(reset), .tick_i(tick),
    .level_o(lv[2]), .busy_o(bz[2]), .dropped_o(dr[2]), .pulse_count_o(pc[2]));
  pulse_stretch_gen #(.HIGH_CYCLES(1), .LOW_CYCLES(1), .RETRIGGER(1'b1), .CNT_W(8)) u_d (
    .clk_i(clk), .reset_i(reset), .tick_i(tick),
    .level_o(lv[3]), .busy_o(bz[3]), .dropped_o(dr[3]), .pulse_count_o(pc[3]));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Timeline model: interval t is the cycle after posedge t. A pulse is the cycle range
  // up to hi_end, followed by low gap cycles up to gp_end.
  int t = 0;
  int hi_end [N];
  int gp_end [N];
  int mcnt   [N];
  bit pend   [N];
  bit mdrop  [N];
  bit mlvl   [N];
  bit mbusy  [N];

  task automatic mstart(input int i);
    hi_end[i] = t + hc[i] - 1;
    gp_end[i] = hi_end[i] + lc[i];
    mcnt[i]   = mcnt[i] + 1;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      mdrop[i] = 1'b0;
      if (reset) begin
        hi_end[i] = -100;
        gp_end[i] = -100;
        mcnt[i]   = 0;
        pend[i]   = 1'b0;
      end else if (t - 1 <= hi_end[i]) begin
        if (tick) begin
          if (rt[i] != 0) begin
            hi_end[i] = t + hc[i] - 1;
            gp_end[i] = hi_end[i] + lc[i];
          end else begin
            mdrop[i] = 1'b1;
          end
        end
      end else if (t - 1 <= gp_end[i]) begin
        if (tick) begin
          if (pend[i]) mdrop[i] = 1'b1;
          else         pend[i]  = 1'b1;
        end
        if (t - 1 == gp_end[i] && pend[i]) begin
          pend[i] = 1'b0;
          mstart(i);
        end
      end else if (tick) begin
        mstart(i);
      end
      mlvl[i]  = (t <= hi_end[i]);
      mbusy[i] = (t <= gp_end[i]);
    end
    t = t + 1;
  end

  int shown = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        checks = checks + 1;
        if (lv[i] !== mlvl[i] || bz[i] !== mbusy[i] || dr[i] !== mdrop[i] || pc[i] !== 8'(mcnt[i])) begin
          errors = errors + 1;
          if (shown < 20) begin
            shown = shown + 1;
            $display("FAIL cycle_cmp inst%0d t=%0d: got lvl=%b busy=%b drop=%b cnt=%0d, expected lvl=%b busy=%b drop=%b cnt=%0d",
                     i, t - 1, lv[i], bz[i], dr[i], pc[i], mlvl[i], mbusy[i], mdrop[i], 8'(mcnt[i]));
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic k);
    reset = r;
    tick  = k;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] ed(input int e);
    logic [63:0] one;
    one = 64'd1;
    return one << e;
  endfunction

  // bits for spec cycles a..b (cycle c is the interval after edge c-1)
  function automatic logic [63:0] cyc(input int a, input int b);
    logic [63:0] m;
    m = '0;
    for (int c = a; c <= b; c++) m = m | ed(c - 1);
    return m;
  endfunction

  logic [63:0] lh [N];
  logic [63:0] bh [N];
  logic [63:0] dh [N];
  logic [7:0]  probe [N];

  task automatic scen(input logic [63:0] tk, input logic [63:0] rs, input int probe_e);
    for (int i = 0; i < N; i++) begin
      lh[i] = '0; bh[i] = '0; dh[i] = '0; probe[i] = 8'hxx;
    end
    for (int e = 0; e < 40; e++) begin
      step(rs[e], tk[e]);
      for (int i = 0; i < N; i++) begin
        lh[i][e] = lv[i];
        bh[i][e] = bz[i];
        dh[i][e] = dr[i];
        if (e == probe_e) probe[i] = pc[i];
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    @(negedge clk);
    step(1'b1, 1'b0);
    chk_en = 1'b1;

    // single tick at edge 10; counts probed during reset/idle stretch
    scen(ed(10), 64'h7, 9);
    chk("s2_level_a", lh[0], cyc(11, 14));
    chk("s2_busy_a", bh[0], cyc(11, 16));
    chk("s2_drop_a", dh[0], 64'd0);
    chk("s2_count_a", 64'(pc[0]), 64'd1);
    chk("s1_count_idle_a", 64'(probe[0]), 64'd0);

    // tick while high
    scen(ed(10) | ed(12), 64'h7, 9);
    chk("s3_level_a", lh[0], cyc(11, 14));
    chk("s3_drop_a", dh[0], cyc(13, 13));
    chk("s3_count_a", 64'(pc[0]), 64'd1);
    chk("s3_level_retrig", lh[1], cyc(11, 16));
    chk("s3_drop_retrig", dh[1], 64'd0);
    chk("s3_count_retrig", 64'(pc[1]), 64'd1);

    // tick during gap becomes pending; also the zero-gap instance
    scen(ed(10) | ed(15), 64'h7, 9);
    chk("s4_level_a", lh[0], cyc(11, 14) | cyc(17, 20));
    chk("s4_busy_a", bh[0], cyc(11, 22));
    chk("s4_count_a", 64'(pc[0]), 64'd2);
    chk("s5_level_nogap", lh[2], cyc(11, 14) | cyc(16, 19));
    chk("s5_count_nogap", 64'(pc[2]), 64'd2);

    scen(ed(10) | ed(15) | ed(16), 64'h7, 9);
    chk("s4b_drop_a", dh[0], cyc(17, 17));
    chk("s4b_level_a", lh[0], cyc(11, 14) | cyc(17, 20));

    // reset mid-pulse
    scen(ed(10) | ed(14), 64'h7 | ed(12), 12);
    chk("s6_level_a", lh[0], cyc(11, 12) | cyc(15, 18));
    chk("s6_busy_a", bh[0], cyc(11, 12) | cyc(15, 20));
    chk("s6_count_after_rst", 64'(probe[0]), 64'd0);
    chk("s6_count_a", 64'(pc[0]), 64'd1);

    // pulse_count wrap
    step(1'b1, 1'b0);
    for (int n = 0; n < 255; n++) begin
      step(1'b0, 1'b1);
      for (int k = 0; k < 7; k++) step(1'b0, 1'b0);
    end
    chk("wrap_count_255", 64'(pc[0]), 64'd255);
    step(1'b0, 1'b1);
    chk("wrap_count_0", 64'(pc[0]), 64'd0);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b0);

    // randomized traffic, including held-high tick blocks and sporadic resets
    for (int blk = 0; blk < 16; blk++) begin
      case ($urandom_range(0, 3))
        0: p = 5;
        1: p = 25;
        2: p = 60;
        default: p = 100;
      endcase
      for (int k = 0; k < 200; k++)
        step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < p);
    end
    step(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
